// File: rtl/core_irq_ctrl.sv
// Interrupt/exception sequencer: latches IRQ rising edges, prioritises them
// against the current nesting level, pushes {pc, sr, prio} on a context stack
// and emits one-cycle redirect pulses for takes and for eret returns.
// Ports: clk/rst; irq, mask_we/mask_wdata, swi, eret, ie, id_pc, sr in;
//        except/set_pc/new_pc/write_mode/mode/irq_ack/restore_sr/eret_err
//        pulses out; epc/esr (top of stack) and depth status out.

package core_irq_ctrl_pkg;
   typedef enum logic [1:0] {
      MODE_NONE = 2'd0,
      MODE_IRQ  = 2'd1,
      MODE_SWI  = 2'd2
   } mode_t;
endpackage

module core_irq_ctrl
   import core_irq_ctrl_pkg::*;
#(
   parameter int                NUM_IRQ    = 8,
   parameter int                ADDR_W     = 32,
   parameter int                SR_W       = 32,
   parameter int                NEST_DEPTH = 2,
   parameter logic [ADDR_W-1:0] VEC_BASE   = 'h100,
   parameter logic [ADDR_W-1:0] VEC_STRIDE = 'h10,
   parameter logic [ADDR_W-1:0] VEC_SWI    = 'h80
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_IRQ-1:0]                irq,
   input  logic                              mask_we,
   input  logic [NUM_IRQ-1:0]                mask_wdata,
   input  logic                              swi,
   input  logic                              eret,
   input  logic                              ie,
   input  logic [ADDR_W-1:0]                 id_pc,
   input  logic [SR_W-1:0]                   sr,
   output logic                              except,
   output logic                              set_pc,
   output logic [ADDR_W-1:0]                 new_pc,
   output logic                              write_mode,
   output mode_t                             mode,
   output logic [NUM_IRQ-1:0]                irq_ack,
   output logic [ADDR_W-1:0]                 epc,
   output logic [SR_W-1:0]                   esr,
   output logic                              restore_sr,
   output logic [$clog2(NEST_DEPTH+1)-1:0]   depth,
   output logic                              eret_err
);

   localparam int PRIO_W  = $clog2(NUM_IRQ + 1);
   localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);

   // Edge history, pending latches and enable mask
   logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;

   // Context stack; a stored prio of NUM_IRQ marks a SWI frame
   logic [ADDR_W-1:0] stk_pc_q   [NEST_DEPTH];
   logic [ADDR_W-1:0] stk_pc_d   [NEST_DEPTH];
   logic [SR_W-1:0]   stk_sr_q   [NEST_DEPTH];
   logic [SR_W-1:0]   stk_sr_d   [NEST_DEPTH];
   logic [PRIO_W-1:0] stk_prio_q [NEST_DEPTH];
   logic [PRIO_W-1:0] stk_prio_d [NEST_DEPTH];
   logic [DEPTH_W-1:0] depth_q, depth_d;

   // Registered output pulses
   logic               except_q, except_d;
   logic               set_pc_q, set_pc_d;
   logic               write_mode_q, write_mode_d;
   logic               restore_sr_q, restore_sr_d;
   logic               eret_err_q, eret_err_d;
   logic [ADDR_W-1:0]  new_pc_q, new_pc_d;
   logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;
   mode_t              mode_q, mode_d;

   // Combinational helpers
   logic [NUM_IRQ-1:0] rise, eligible;
   logic [PRIO_W-1:0]  win_idx;
   logic [DEPTH_W-1:0] depth_eff;
   logic [ADDR_W-1:0]  eff_pc;
   logic [PRIO_W-1:0]  eff_prio, below_prio;
   logic               take_ok, irq_take, swi_take, eret_ok;
   logic [ADDR_W-1:0]  top_pc;
   logic [SR_W-1:0]    top_sr;

   always_comb begin
      rise     = irq & ~irq_prev_q;
      // A rise seen this cycle can win immediately, giving a one-cycle take.
      eligible = (pending_q | rise) & mask_q;

      win_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_idx = PRIO_W'(i);
         end
      end

      // The pop of an eret is committed at the end of its pulse cycle so that
      // epc/esr still show the returning frame while the core restores from
      // them. Decisions made during that cycle use the post-pop view.
      depth_eff = depth_q - DEPTH_W'(restore_sr_q);

      eff_pc     = '0;
      eff_prio   = '0;
      below_prio = '0;
      top_pc     = '0;
      top_sr     = '0;
      for (int k = 0; k < NEST_DEPTH; k++) begin
         if (k == int'(depth_eff) - 1) begin
            eff_pc   = stk_pc_q[k];
            eff_prio = stk_prio_q[k];
         end
         if (k == int'(depth_eff) - 2) begin
            below_prio = stk_prio_q[k];
         end
         if (k == int'(depth_q) - 1) begin
            top_pc = stk_pc_q[k];
            top_sr = stk_sr_q[k];
         end
      end

      eret_ok  = eret && (depth_eff != '0);
      take_ok  = ie && !eret && !except_q && (int'(depth_eff) < NEST_DEPTH);
      irq_take = take_ok && (|eligible) &&
                 ((depth_eff == '0) || (win_idx < eff_prio));
      swi_take = take_ok && swi && !irq_take && (depth_eff == '0);
   end

   always_comb begin
      irq_prev_d   = irq;
      pending_d    = (pending_q & ~irq_ack_q) | rise;
      mask_d       = mask_we ? mask_wdata : mask_q;
      stk_pc_d     = stk_pc_q;
      stk_sr_d     = stk_sr_q;
      stk_prio_d   = stk_prio_q;
      depth_d      = depth_eff;
      except_d     = 1'b0;
      set_pc_d     = 1'b0;
      write_mode_d = 1'b0;
      restore_sr_d = 1'b0;
      eret_err_d   = 1'b0;
      new_pc_d     = '0;
      irq_ack_d    = '0;
      mode_d       = MODE_NONE;

      if (eret) begin
         if (eret_ok) begin
            set_pc_d     = 1'b1;
            write_mode_d = 1'b1;
            restore_sr_d = 1'b1;
            new_pc_d     = eff_pc;
            if (depth_eff == DEPTH_W'(1)) begin
               mode_d = MODE_NONE;
            end else if (below_prio == PRIO_W'(NUM_IRQ)) begin
               mode_d = MODE_SWI;
            end else begin
               mode_d = MODE_IRQ;
            end
         end else begin
            eret_err_d = 1'b1;
         end
      end else if (irq_take || swi_take) begin
         for (int k = 0; k < NEST_DEPTH; k++) begin
            if (k == int'(depth_eff)) begin
               stk_pc_d[k]   = id_pc;
               stk_sr_d[k]   = sr;
               stk_prio_d[k] = irq_take ? win_idx : PRIO_W'(NUM_IRQ);
            end
         end
         depth_d      = depth_eff + DEPTH_W'(1);
         except_d     = 1'b1;
         set_pc_d     = 1'b1;
         write_mode_d = 1'b1;
         if (irq_take) begin
            mode_d    = MODE_IRQ;
            new_pc_d  = VEC_BASE + ADDR_W'(win_idx) * VEC_STRIDE;
            irq_ack_d = NUM_IRQ'(1) << win_idx;
         end else begin
            mode_d    = MODE_SWI;
            new_pc_d  = VEC_SWI;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         irq_prev_q   <= '0;
         pending_q    <= '0;
         mask_q       <= '1;
         depth_q      <= '0;
         except_q     <= 1'b0;
         set_pc_q     <= 1'b0;
         write_mode_q <= 1'b0;
         restore_sr_q <= 1'b0;
         eret_err_q   <= 1'b0;
         new_pc_q     <= '0;
         irq_ack_q    <= '0;
         mode_q       <= MODE_NONE;
         for (int k = 0; k < NEST_DEPTH; k++) begin
            stk_pc_q[k]   <= '0;
            stk_sr_q[k]   <= '0;
            stk_prio_q[k] <= '0;
         end
      end else begin
         irq_prev_q   <= irq_prev_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         depth_q      <= depth_d;
         except_q     <= except_d;
         set_pc_q     <= set_pc_d;
         write_mode_q <= write_mode_d;
         restore_sr_q <= restore_sr_d;
         eret_err_q   <= eret_err_d;
         new_pc_q     <= new_pc_d;
         irq_ack_q    <= irq_ack_d;
         mode_q       <= mode_d;
         for (int k = 0; k < NEST_DEPTH; k++) begin
            stk_pc_q[k]   <= stk_pc_d[k];
            stk_sr_q[k]   <= stk_sr_d[k];
            stk_prio_q[k] <= stk_prio_d[k];
         end
      end
   end

   assign except     = except_q;
   assign set_pc     = set_pc_q;
   assign new_pc     = new_pc_q;
   assign write_mode = write_mode_q;
   assign mode       = mode_q;
   assign irq_ack    = irq_ack_q;
   assign restore_sr = restore_sr_q;
   assign eret_err   = eret_err_q;
   assign depth      = depth_q;
   assign epc        = top_pc;
   assign esr        = top_sr;

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Directed table-driven bench for core_irq_ctrl with default parameters.
// Each row: inputs held for one cycle, expected outputs right after that edge.
// Reset-abort and reset-release corner cases follow as hand-written steps.

module tb_core_irq_ctrl;
   import core_irq_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq;
   logic        mask_we;
   logic [7:0]  mask_wdata;
   logic        swi, eret, ie;
   logic [31:0] id_pc, sr;
   logic        except, set_pc, write_mode, restore_sr, eret_err;
   logic [31:0] new_pc, epc, esr;
   mode_t       mode;
   logic [7:0]  irq_ack;
   logic [1:0]  depth;

   int checks   = 0;
   int failures = 0;

   core_irq_ctrl dut (
      .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .swi(swi), .eret(eret), .ie(ie), .id_pc(id_pc), .sr(sr),
      .except(except), .set_pc(set_pc), .new_pc(new_pc), .write_mode(write_mode),
      .mode(mode), .irq_ack(irq_ack), .epc(epc), .esr(esr),
      .restore_sr(restore_sr), .depth(depth), .eret_err(eret_err)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] SR_XOR = 32'h5A5A_0000;
   localparam logic [31:0] PC_IDLE = 32'h3FC;

   typedef struct {
      logic [7:0]  irq;
      logic        swi, eret, ie, mwe;
      logic [7:0]  mwd;
      logic [31:0] pc;
      logic        exc, spc;
      logic [31:0] npc;
      logic [7:0]  ack;
      mode_t       md;
      logic [1:0]  dep;
      logic        err;
      logic [31:0] epc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [7:0] i_irq, input logic i_swi, input logic i_eret,
                      input logic i_ie, input logic i_mwe, input logic [7:0] i_mwd,
                      input logic [31:0] i_pc, input logic e_exc, input logic e_spc,
                      input logic [31:0] e_npc, input logic [7:0] e_ack, input mode_t e_md,
                      input logic [1:0] e_dep, input logic e_err, input logic [31:0] e_epc);
      vec_t v;
      v.irq = i_irq; v.swi = i_swi; v.eret = i_eret; v.ie = i_ie; v.mwe = i_mwe;
      v.mwd = i_mwd; v.pc = i_pc; v.exc = e_exc; v.spc = e_spc; v.npc = e_npc;
      v.ack = e_ack; v.md = e_md; v.dep = e_dep; v.err = e_err; v.epc = e_epc;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] i_irq, input logic i_swi, input logic i_eret,
                        input logic i_ie, input logic i_mwe, input logic [7:0] i_mwd,
                        input logic [31:0] i_pc);
      irq = i_irq; swi = i_swi; eret = i_eret; ie = i_ie;
      mask_we = i_mwe; mask_wdata = i_mwd; id_pc = i_pc; sr = i_pc ^ SR_XOR;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Basic take (3 -> 'h130)
      add(8'h08,0,0,1,0,8'h00,32'h40,   1,1,32'h130,8'h08,MODE_IRQ, 2'd1,0,32'h40);
      add(8'h00,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd1,0,32'h40);
      add(8'h00,0,1,1,0,8'h00,PC_IDLE,  0,1,32'h40, 8'h00,MODE_NONE,2'd1,0,32'h40);
      add(8'h00,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);
      // 5 and 2 together: 2 first, 5 after return
      add(8'h24,0,0,1,0,8'h00,32'h50,   1,1,32'h120,8'h04,MODE_IRQ, 2'd1,0,32'h50);
      add(8'h00,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd1,0,32'h50);
      add(8'h00,0,1,1,0,8'h00,PC_IDLE,  0,1,32'h50, 8'h00,MODE_NONE,2'd1,0,32'h50);
      add(8'h00,0,0,1,0,8'h00,32'h60,   1,1,32'h150,8'h20,MODE_IRQ, 2'd1,0,32'h60);
      add(8'h00,0,1,1,0,8'h00,PC_IDLE,  0,1,32'h60, 8'h00,MODE_NONE,2'd1,0,32'h60);
      add(8'h00,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);
      // Nesting 4 -> 1, then 0 blocked by full stack until a return
      add(8'h10,0,0,1,0,8'h00,32'h70,   1,1,32'h140,8'h10,MODE_IRQ, 2'd1,0,32'h70);
      add(8'h12,0,0,1,0,8'h00,32'h74,   0,0,32'h0,  8'h00,MODE_NONE,2'd1,0,32'h70);
      add(8'h12,0,0,1,0,8'h00,32'h78,   1,1,32'h110,8'h02,MODE_IRQ, 2'd2,0,32'h78);
      add(8'h13,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd2,0,32'h78);
      add(8'h13,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd2,0,32'h78);
      add(8'h13,0,1,1,0,8'h00,PC_IDLE,  0,1,32'h78, 8'h00,MODE_IRQ, 2'd2,0,32'h78);
      add(8'h13,0,0,1,0,8'h00,32'h7C,   1,1,32'h100,8'h01,MODE_IRQ, 2'd2,0,32'h7C);
      add(8'h13,0,1,1,0,8'h00,PC_IDLE,  0,1,32'h7C, 8'h00,MODE_IRQ, 2'd2,0,32'h7C);
      add(8'h13,0,1,1,0,8'h00,PC_IDLE,  0,1,32'h70, 8'h00,MODE_NONE,2'd1,0,32'h70);
      add(8'h00,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);
      // SWI loses to a rising IRQ, then taken after the return
      add(8'h80,1,0,1,0,8'h00,32'h90,   1,1,32'h170,8'h80,MODE_IRQ, 2'd1,0,32'h90);
      add(8'h00,1,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd1,0,32'h90);
      add(8'h00,1,1,1,0,8'h00,PC_IDLE,  0,1,32'h90, 8'h00,MODE_NONE,2'd1,0,32'h90);
      add(8'h00,1,0,1,0,8'h00,32'hA0,   1,1,32'h80, 8'h00,MODE_SWI, 2'd1,0,32'hA0);
      add(8'h00,0,1,1,0,8'h00,PC_IDLE,  0,1,32'hA0, 8'h00,MODE_NONE,2'd1,0,32'hA0);
      add(8'h00,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);
      // eret at depth 0; eret racing an IRQ rise
      add(8'h00,0,1,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,1,32'h0);
      add(8'h00,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);
      add(8'h01,0,0,1,0,8'h00,32'hB0,   1,1,32'h100,8'h01,MODE_IRQ, 2'd1,0,32'hB0);
      add(8'h00,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd1,0,32'hB0);
      add(8'h04,0,1,1,0,8'h00,PC_IDLE,  0,1,32'hB0, 8'h00,MODE_NONE,2'd1,0,32'hB0);
      add(8'h04,0,0,1,0,8'h00,32'hC0,   1,1,32'h120,8'h04,MODE_IRQ, 2'd1,0,32'hC0);
      add(8'h00,0,1,1,0,8'h00,PC_IDLE,  0,1,32'hC0, 8'h00,MODE_NONE,2'd1,0,32'hC0);
      add(8'h00,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);
      // ie=0 holds a pending line; mask holds another
      add(8'h08,0,0,0,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);
      add(8'h00,0,0,0,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);
      add(8'h00,0,0,1,0,8'h00,32'hD0,   1,1,32'h130,8'h08,MODE_IRQ, 2'd1,0,32'hD0);
      add(8'h00,0,1,1,0,8'h00,PC_IDLE,  0,1,32'hD0, 8'h00,MODE_NONE,2'd1,0,32'hD0);
      add(8'h00,0,0,1,1,8'hFE,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);
      add(8'h01,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);
      add(8'h00,0,0,1,1,8'hFF,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);
      add(8'h00,0,0,1,0,8'h00,32'hE0,   1,1,32'h100,8'h01,MODE_IRQ, 2'd1,0,32'hE0);
      add(8'h00,0,1,1,0,8'h00,PC_IDLE,  0,1,32'hE0, 8'h00,MODE_NONE,2'd1,0,32'hE0);
      add(8'h00,0,0,1,0,8'h00,PC_IDLE,  0,0,32'h0,  8'h00,MODE_NONE,2'd0,0,32'h0);

      // Reset state
      rst = 1'b1;
      drive(8'h00, 0, 0, 0, 0, 8'h00, 32'h0);
      step();
      step();
      chk("rst_except",  -1, 64'(except), 64'd0);
      chk("rst_set_pc",  -1, 64'(set_pc), 64'd0);
      chk("rst_new_pc",  -1, 64'(new_pc), 64'd0);
      chk("rst_mode",    -1, 64'(mode),   64'(MODE_NONE));
      chk("rst_depth",   -1, 64'(depth),  64'd0);
      chk("rst_epc",     -1, 64'(epc),    64'd0);
      chk("rst_irq_ack", -1, 64'(irq_ack), 64'd0);
      rst = 1'b0;

      foreach (vecs[r]) begin
         drive(vecs[r].irq, vecs[r].swi, vecs[r].eret, vecs[r].ie,
               vecs[r].mwe, vecs[r].mwd, vecs[r].pc);
         step();
         chk("except",     r, 64'(except),     64'(vecs[r].exc));
         chk("set_pc",     r, 64'(set_pc),     64'(vecs[r].spc));
         chk("write_mode", r, 64'(write_mode), 64'(vecs[r].spc));
         chk("restore_sr", r, 64'(restore_sr), 64'(vecs[r].spc & ~vecs[r].exc));
         chk("new_pc",     r, 64'(new_pc),     64'(vecs[r].npc));
         chk("irq_ack",    r, 64'(irq_ack),    64'(vecs[r].ack));
         chk("mode",       r, 64'(mode),       64'(vecs[r].md));
         chk("depth",      r, 64'(depth),      64'(vecs[r].dep));
         chk("eret_err",   r, 64'(eret_err),   64'(vecs[r].err));
         chk("epc",        r, 64'(epc),        64'(vecs[r].epc));
         chk("esr",        r, 64'(esr),
             64'((vecs[r].epc == 32'h0) ? 32'h0 : (vecs[r].epc ^ SR_XOR)));
      end

      // Mask everything, raise a line: nothing taken
      drive(8'h00, 0, 0, 1, 1, 8'h00, PC_IDLE);
      step();
      drive(8'h02, 0, 0, 1, 0, 8'h00, PC_IDLE);
      step();
      chk("masked_no_take", 100, 64'(except), 64'd0);
      // Reset with the line held high: idle, mask back to all-ones
      rst = 1'b1;
      step();
      chk("rst_hold_except", 101, 64'(except), 64'd0);
      chk("rst_hold_depth",  101, 64'(depth),  64'd0);
      // Release: held line is seen as a fresh rise
      rst = 1'b0;
      drive(8'h02, 0, 0, 1, 0, 8'h00, 32'hF0);
      step();
      chk("rel_except",  102, 64'(except),  64'd1);
      chk("rel_new_pc",  102, 64'(new_pc),  64'h110);
      chk("rel_irq_ack", 102, 64'(irq_ack), 64'h02);
      chk("rel_epc",     102, 64'(epc),     64'hF0);
      // Reset during the take pulse aborts it
      rst = 1'b1;
      step();
      chk("abort_take_except", 103, 64'(except),  64'd0);
      chk("abort_take_ack",    103, 64'(irq_ack), 64'd0);
      chk("abort_take_depth",  103, 64'(depth),   64'd0);
      chk("abort_take_epc",    103, 64'(epc),     64'd0);
      rst = 1'b0;
      drive(8'h00, 0, 0, 1, 0, 8'h00, PC_IDLE);
      step();
      drive(8'h04, 0, 0, 1, 0, 8'h00, 32'hF4);
      step();
      chk("pre_eret_take", 104, 64'(new_pc), 64'h120);
      // Reset on the eret edge: no return pulse
      rst = 1'b1;
      drive(8'h00, 0, 1, 1, 0, 8'h00, PC_IDLE);
      step();
      chk("abort_eret_set_pc",  105, 64'(set_pc),     64'd0);
      chk("abort_eret_restore", 105, 64'(restore_sr), 64'd0);
      chk("abort_eret_depth",   105, 64'(depth),      64'd0);
      rst = 1'b0;
      drive(8'h00, 0, 0, 1, 0, 8'h00, PC_IDLE);
      step();
      chk("post_rst_idle_err", 106, 64'(eret_err), 64'd0);
      chk("post_rst_idle_pc",  106, 64'(set_pc),   64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
